// File: rtl/mem_pkg.sv
// Shared definitions for the data-BRAM access path.
//   - access size encodings carried on req_size
//   - FSM state encoding for bram_access_ctrl
//   - default BRAM word-address and data widths
//   - bad_access(): alignment / reserved-size check done at accept time
package mem_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  // 1 when the access cannot be performed: a half that is not 2-byte
  // aligned, a word that is not 4-byte aligned, or the reserved size.
  function automatic logic bad_access(input logic [1:0] size,
                                      input logic [1:0] lane);
    case (size)
      SZ_BYTE: bad_access = 1'b0;
      SZ_HALF: bad_access = lane[0];
      SZ_WORD: bad_access = |lane;
      default: bad_access = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_mux.sv
// Combinational lane steering between a 32-bit memory word and a
// byte/half/word access (little-endian, lane = byte address [1:0]).
// Ports:
//   word       in  32  current memory word
//   wdata      in  32  store data, right-aligned
//   lane       in  2   byte address [1:0]
//   size       in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   sgn        in  1   sign-extend loads when 1
//   load_data  out 32  selected lane of word, sign/zero extended
//   merge_data out 32  word with wdata written into the selected lane
import mem_pkg::*;

module lane_mux (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{sgn & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sgn & half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase

    merge_data = word;
    case (size)
      SZ_BYTE: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) merge_data[31:16] = wdata[15:0];
        else         merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/bram_access_ctrl.sv
// Initiator-side controller for the single-port data BRAM. Accepts one
// byte/half/word load or store at a time and answers with a one-cycle
// response pulse. Sub-word stores are read-modify-write because the BRAM
// only has a whole-word write enable.
// Ports:
//   clka, rsta                    clock, synchronous active-high reset
//   req_valid/req_ready           request channel
//   req_we/size/signed/addr/wdata request fields, latched at handshake
//   resp_valid/err/rdata          one-cycle response
//   mem_en/we/addr/din, mem_dout  BRAM port A (asynchronous read)
//   dbg_state                     current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is high only in IDLE outside reset, so
// one request is outstanding at a time. resp_valid is a single-cycle pulse
// with no back-pressure.
import mem_pkg::*;

module bram_access_ctrl #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [2:0]        dbg_state
);

  logic [2:0]        state;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              sgn_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  // Holds raw store data from accept, then the merged word after RMW_RD;
  // it is what WRITE drives onto mem_din in both store flavours.
  logic [DATA_W-1:0] merge_q;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;
  logic              bad;

  // Address bits above the BRAM range alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  assign bad = bad_access(req_size, req_addr[1:0]);

  lane_mux u_lane_mux (
    .word       (mem_dout),
    .wdata      (merge_q),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .sgn        (sgn_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clka) begin
    if (rsta) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // req_ready is 1 here, so req_valid alone means a handshake.
          if (req_valid) begin
            addr_q  <= req_addr[ADDR_W+1:0];
            size_q  <= req_size;
            sgn_q   <= req_signed;
            err_q   <= bad;
            rdata_q <= '0;
            merge_q <= req_wdata;
            if (bad)                   state <= ST_RESP;
            else if (!req_we)          state <= ST_LOAD;
            else if (req_size == SZ_WORD) state <= ST_WRITE;
            else                       state <= ST_RMW_RD;
          end
        end
        ST_LOAD: begin
          rdata_q <= load_data;
          state   <= ST_RESP;
        end
        ST_RMW_RD: begin
          merge_q <= merge_data;
          state   <= ST_WRITE;
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // All outputs are decoded from state and latched registers only.
  assign req_ready  = (state == ST_IDLE) & ~rsta;
  assign mem_en     = (state == ST_LOAD) | (state == ST_RMW_RD) | (state == ST_WRITE);
  assign mem_we     = (state == ST_WRITE);
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_din    = (state == ST_WRITE) ? merge_q : '0;
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Directed bench for bram_access_ctrl with a behavioural BRAM model.
module tb_bram_access_ctrl;
  import mem_pkg::*;

  // clock / reset
  logic clka = 1'b0;
  always #5 clka = ~clka;
  logic rsta = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic [2:0]  dbg_state;

  bram_access_ctrl dut (
    .clka(clka), .rsta(rsta),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  // BRAM model: asynchronous read, whole-word synchronous write
  logic [31:0] bram [0:16383];
  assign mem_dout = bram[mem_addr];
  always @(posedge clka) if (mem_en && mem_we) bram[mem_addr] <= mem_din;

  int we_cnt = 0, en_cnt = 0, resp_cnt = 0;
  always @(negedge clka) begin
    if (mem_we) we_cnt++;
    if (mem_en) en_cnt++;
    if (resp_valid) resp_cnt++;
  end

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and waits for its response. lat counts cycles from
  // the handshake cycle (0) to the cycle where resp_valid is seen.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] rdata);
    int guard;
    @(negedge clka);
    req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clka); guard++; end
    @(negedge clka);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin @(negedge clka); lat++; end
    err = resp_err;
    rdata = resp_rdata;
  endtask

  int lat, w0, e0, r0, idx, acc[3], got;
  logic err;
  logic [31:0] rd;
  logic [31:0] b2b_addr[3];
  logic [31:0] b2b_exp[3];

  initial begin
    for (int i = 0; i < 16384; i++) bram[i] = '0;

    // reset state
    repeat (3) @(negedge clka);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rsta = 1'b0;
    @(negedge clka);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // word store then word load
    w0 = we_cnt;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h1000, 32'hDEADBEEF, lat, err, rd);
    chk("sw_lat", lat, 2);
    chk("sw_err", {31'd0, err}, 32'd0);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_we_pulses", we_cnt - w0, 1);
    chk("sw_mem_addr", {18'd0, mem_addr}, 32'h400);
    chk("sw_bram", bram[14'h400], 32'hDEADBEEF);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, lat, err, rd);
    chk("lw_lat", lat, 2);
    chk("lw_rdata", rd, 32'hDEADBEEF);

    // byte store (RMW) and byte loads
    w0 = we_cnt;
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h1001, 32'h000000A5, lat, err, rd);
    chk("sb_lat", lat, 3);
    chk("sb_we_pulses", we_cnt - w0, 1);
    chk("sb_bram", bram[14'h400], 32'hDEADA5EF);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h1001, 32'h0, lat, err, rd);
    chk("lb_signed", rd, 32'hFFFFFFA5);
    chk("lb_lat", lat, 2);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h1001, 32'h0, lat, err, rd);
    chk("lbu", rd, 32'h000000A5);

    // half load / half store on upper lane
    do_req(1'b0, SZ_HALF, 1'b1, 32'h1002, 32'h0, lat, err, rd);
    chk("lh_signed_hi", rd, 32'hFFFFDEAD);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h1002, 32'hFFFF1234, lat, err, rd);
    chk("sh_lat", lat, 3);
    chk("sh_bram", bram[14'h400], 32'h1234A5EF);

    // lane 0 byte store, more extraction cases, address aliasing
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h1000, 32'hFFFFFF11, lat, err, rd);
    chk("sb0_bram", bram[14'h400], 32'h1234A511);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h1000, 32'h0, lat, err, rd);
    chk("lbu_lane0", rd, 32'h00000011);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h1003, 32'h0, lat, err, rd);
    chk("lb_lane3_pos", rd, 32'h00000012);
    do_req(1'b0, SZ_HALF, 1'b0, 32'h1000, 32'h0, lat, err, rd);
    chk("lhu_lo", rd, 32'h0000A511);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h1000, 32'h0, lat, err, rd);
    chk("lh_signed_lo", rd, 32'hFFFFA511);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h0008_1000, 32'h0, lat, err, rd);
    chk("lw_alias", rd, 32'h1234A511);

    // errors: no memory access, response one cycle after handshake
    e0 = en_cnt; w0 = we_cnt;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h1002, 32'h0, lat, err, rd);
    chk("err_lw_lat", lat, 1);
    chk("err_lw_err", {31'd0, err}, 32'd1);
    chk("err_lw_rdata", rd, 32'd0);
    do_req(1'b1, SZ_HALF, 1'b0, 32'h1003, 32'h0000BEEF, lat, err, rd);
    chk("err_sh_lat", lat, 1);
    chk("err_sh_err", {31'd0, err}, 32'd1);
    do_req(1'b0, SZ_RSVD, 1'b0, 32'h1000, 32'h0, lat, err, rd);
    chk("err_rsvd_err", {31'd0, err}, 32'd1);
    chk("err_rsvd_rdata", rd, 32'd0);
    chk("err_no_en", en_cnt - e0, 0);
    chk("err_no_we", we_cnt - w0, 0);
    chk("err_bram", bram[14'h400], 32'h1234A511);

    // reset during RMW_RD: request dropped, nothing written
    @(negedge clka);
    w0 = we_cnt; r0 = resp_cnt;
    req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
    req_addr = 32'h1000; req_wdata = 32'h77; req_valid = 1'b1;
    chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clka);
    chk("rmw_rst_state", {29'd0, dbg_state}, {29'd0, ST_RMW_RD});
    rsta = 1'b1; req_valid = 1'b0;
    @(negedge clka);
    chk("rmw_rst_ready_in_rst", {31'd0, req_ready}, 32'd0);
    chk("rmw_rst_we", {31'd0, mem_we}, 32'd0);
    rsta = 1'b0;
    @(negedge clka);
    chk("rmw_rst_ready_after", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clka);
    chk("rmw_rst_no_we", we_cnt - w0, 0);
    chk("rmw_rst_no_resp", resp_cnt - r0, 0);
    chk("rmw_rst_bram", bram[14'h400], 32'h1234A511);

    // reset during WRITE: the write still commits, no response
    r0 = resp_cnt;
    req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h2000;
    req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(negedge clka);
    chk("wr_rst_state", {29'd0, dbg_state}, {29'd0, ST_WRITE});
    rsta = 1'b1; req_valid = 1'b0;
    @(negedge clka);
    rsta = 1'b0;
    repeat (3) @(negedge clka);
    chk("wr_rst_commit", bram[14'h800], 32'hCAFEF00D);
    chk("wr_rst_no_resp", resp_cnt - r0, 0);

    // back-to-back word loads with req_valid held high
    do_req(1'b1, SZ_WORD, 1'b0, 32'h3000, 32'h01020304, lat, err, rd);
    chk("sw3_lat", lat, 2);
    b2b_addr[0] = 32'h1000; b2b_exp[0] = 32'h1234A511;
    b2b_addr[1] = 32'h2000; b2b_exp[1] = 32'hCAFEF00D;
    b2b_addr[2] = 32'h3000; b2b_exp[2] = 32'h01020304;
    idx = 0; got = 0;
    req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clka);
      if (resp_valid) begin
        got++;
        if (exp_q.size() > 0) chk("b2b_rdata", resp_rdata, exp_q.pop_front());
        else chk("b2b_extra_resp", 32'd1, 32'd0);
      end
      if (idx < 3) begin
        req_addr = b2b_addr[idx];
        req_valid = 1'b1;
        if (req_ready) begin
          acc[idx] = c;
          exp_q.push_back(b2b_exp[idx]);
          idx++;
        end
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", idx, 3);
    chk("b2b_gap01", acc[1] - acc[0], 3);
    chk("b2b_gap12", acc[2] - acc[1], 3);
    chk("b2b_resp_count", got, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_access_ctrl.md
Name: bram_access_ctrl

Overview:
Initiator-side controller that drives the single-port data BRAM (clka/ena/wea/addra/dina/douta, 14-bit word address, 32-bit data, asynchronous read, 1-bit whole-word write enable) on behalf of the CPU load/store path. It accepts one byte/half/word load or store at a time over a valid/ready request channel and returns a one-cycle response pulse. Sub-word stores are handled as read-modify-write because the memory has no byte enables. It sits between the memory stage and the data BRAM instance.

Parameters:
ADDR_W, 14, BRAM word-address width; mem_addr width; request byte-address bits [ADDR_W+1:2] select the word.
DATA_W, 32, data width; fixed at 32, and any other value is unsupported.

Ports:
clka  in  1  clock; all state updates on the rising edge
rsta  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
req_signed  in  1  loads only: sign-extend (1) or zero-extend (0)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid: misaligned access or reserved size
resp_rdata  out  32  load result, extended; 0 for stores and errors
mem_en  out  1  to BRAM ena
mem_we  out  1  to BRAM wea
mem_addr  out  ADDR_W  to BRAM addra
mem_din  out  32  to BRAM dina
mem_dout  in  32  from BRAM douta; combinational, valid in the same cycle as mem_addr

Behaviour:
- Reset: state IDLE. resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0, all latched request registers 0. req_ready=0 while rsta=1.
- req_ready = (state==IDLE) & ~rsta. Handshake occurs when req_valid & req_ready; request fields are latched on that edge. Only one request is outstanding at a time.
- Memory outputs are Moore-decoded from state and latched registers. There is no combinational path from req_* to mem_*.
- Byte order is little-endian: lane = addr[1:0]; byte k occupies bits [8k+7:8k]; half uses addr[1].
- Error check at accept: half with addr[0]=1, word with addr[1:0]!=0, or size=11. Next state RESP with resp_err=1; no memory access.
- States and transitions:
  - IDLE -> LOAD (load), WRITE (word store), RMW_RD (byte/half store), RESP (error).
  - LOAD: mem_en=1, mem_we=0. Extract the lane from mem_dout and extend into the rdata register. -> RESP.
  - RMW_RD: mem_en=1, mem_we=0. Merge req_wdata into the selected lane of mem_dout; hold the result in a merge register. -> WRITE.
  - WRITE: mem_en=1, mem_we=1, mem_din = merge register (or req_wdata for word stores). The write commits on this edge. -> RESP.
  - RESP: resp_valid=1, plus resp_err/resp_rdata. -> IDLE.
- Latency from accept edge T to resp_valid high:
  - load: T+2 cycles
  - word store: T+2 cycles
  - sub-word store: T+3 cycles
  - error: T+1 cycle
- Back-to-back throughput: a new request can be accepted in the cycle after RESP.
- mem_addr = latched req_addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias with no range error.
- A load immediately after a store to the same word returns the new data, because the store has committed before RESP.
- Reset mid-operation: the next state is IDLE and the request is dropped with no response. If rsta is asserted during the WRITE cycle, that write still commits at the edge, since mem_we was already high. If asserted during RMW_RD, no write occurs.
- While idle, mem_en=0 and mem_we=0.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state encoding
  - ADDR_W default
- One natural sub-module, lane_mux: a pure combinational helper with two functions:
  - load extract/extend (word, addr[1:0], size, signed -> 32)
  - store merge (old word, wdata, addr[1:0], size -> 32)
- The FSM stays in bram_access_ctrl.

Test Plan:
- Word store 0x1000 <- 0xDEADBEEF, then word load 0x1000. Required: mem_addr=0x400, we pulses once, load resp_rdata=0xDEADBEEF at T+2.
- Word 0x1000=0xDEADBEEF, byte store addr 0x1001 data 0xA5. Required: RMW read then write 0xDEADA5EF, resp at T+3. Signed byte load 0x1001 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
- Half load addr 0x1002, signed, word 0xDEADA5EF. Required: 0xFFFFDEAD. Half store 0x1002 data 0x1234 -> word becomes 0x1234A5EF.
- Misaligned word load 0x1002 and half store 0x1003. Required: resp_err=1 at T+1, resp_rdata=0, mem_en never asserted.
- rsta asserted during the RMW_RD cycle of a byte store. Required: no mem_we pulse, no resp_valid, word unchanged, req_ready=1 the cycle after reset deasserts.
- req_valid held high for 3 back-to-back word loads. Required: req_ready low during LOAD/RESP, each load accepted 3 cycles apart, all 3 responses correct and in order.
